// File: rtl/cmp_debounce_monitor.sv
// Debounces per-sample comparator flags into a stable relation state, with
// entry counters, a one-cycle change pulse and a sticky bad-flag-code error.
module cmp_debounce_monitor #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             greater,
    input  logic             less,
    input  logic             equal,
    input  logic             clear,
    output logic [1:0]       state,
    output logic             change,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count,
    output logic             flag_err
);

    localparam int unsigned RunW = $clog2(DEBOUNCE + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(DEBOUNCE);
    localparam logic [RunW-1:0] RunOne = RunW'(1);

    typedef enum logic [1:0] {
        RelUnknown = 2'b00,
        RelGt      = 2'b01,
        RelLt      = 2'b10,
        RelEq      = 2'b11
    } rel_e;

    rel_e             state_q, state_d;
    rel_e             cand_q, cand_d;
    rel_e             rel;
    logic [RunW-1:0]  run_q, run_d;
    logic             change_q, change_d;
    logic [CNT_W-1:0] gt_q, gt_d;
    logic [CNT_W-1:0] lt_q, lt_d;
    logic             err_q, err_d;
    logic             onehot;

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        run_d    = run_q;
        change_d = 1'b0;
        gt_d     = gt_q;
        lt_d     = lt_q;
        err_d    = err_q;
        onehot   = ({greater, less, equal} == 3'b100) ||
                   ({greater, less, equal} == 3'b010) ||
                   ({greater, less, equal} == 3'b001);
        rel      = greater ? RelGt : (less ? RelLt : RelEq);

        if (in_valid) begin
            if (!onehot) begin
                // Bad code: keep the candidate but force a fresh run.
                run_d = '0;
                err_d = 1'b1;
            end else begin
                if (rel == cand_q) begin
                    run_d = (run_q == RunMax) ? RunMax : run_q + RunOne;
                end else begin
                    cand_d = rel;
                    run_d  = RunOne;
                end
                if ((run_d == RunMax) && (cand_d != state_q)) begin
                    state_d  = cand_d;
                    change_d = 1'b1;
                    if ((cand_d == RelGt) && (gt_q != '1)) gt_d = gt_q + 1'b1;
                    if ((cand_d == RelLt) && (lt_q != '1)) lt_d = lt_q + 1'b1;
                end
            end
        end

        // Clear overrides any same-cycle increment or error.
        if (clear) begin
            gt_d  = '0;
            lt_d  = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RelUnknown;
            cand_q   <= RelUnknown;
            run_q    <= '0;
            change_q <= 1'b0;
            gt_q     <= '0;
            lt_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            run_q    <= run_d;
            change_q <= change_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            err_q    <= err_d;
        end
    end

    assign state    = state_q;
    assign change   = change_q;
    assign gt_count = gt_q;
    assign lt_count = lt_q;
    assign flag_err = err_q;

endmodule
